vga_timing_ctrl: RTL and testbench

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_timing_ctrl.sv | 131 +++++++++++++
 tb/tb_vga_timing_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and colour constants for the timing controller
// and the pixel generators that feed it.
package vga_pkg;

  localparam int CNT_W   = 10;
  localparam int COLOR_W = 6;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [COLOR_W-1:0] rgb_t;

  // 640x480 @ 60 Hz reference timing
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 1;

  localparam rgb_t RED   = 6'b110000;
  localparam rgb_t BLACK = 6'b000000;

  // True when lo <= val < hi.
  function automatic logic in_zone(input cnt_t val, input int lo, input int hi);
    return (int'(val) >= lo) && (int'(val) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: pixel-rate divider, h/v counters, sync/active decode and
// a one-pixel-latency registered output stage toward the DAC.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [9:0]   colPos,
  output logic [9:0]   rowPos,
  input  logic [5:0]   color,
  output logic [5:0]   vga_rgb,
  output logic         hsync,
  output logic         vsync,
  output logic         video_on,
  output logic         frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT_C = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT_C = cnt_t'(V_ACTIVE);

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic pix_en;

  // Divide-by-1 needs no counter: every clk is a pixel.
  generate
    if (CLK_DIV <= 1) begin : g_no_div
      assign pix_en = 1'b1;
    end else begin : g_div
      localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
      logic [1:0] div_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          div_reg <= '0;
        end else if (div_reg == DIV_LAST) begin
          div_reg <= '0;
        end else begin
          div_reg <= div_reg + 2'd1;
        end
      end

      assign pix_en = (div_reg == DIV_LAST);
    end
  endgenerate

  cnt_t h_cnt_reg, h_cnt_next;
  cnt_t v_cnt_reg, v_cnt_next;

  always_comb begin
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    if (pix_en) begin
      if (h_cnt_reg == H_LAST) begin
        h_cnt_next = '0;
        if (v_cnt_reg == V_LAST) begin
          v_cnt_next = '0;
        end else begin
          v_cnt_next = v_cnt_reg + cnt_t'(1);
        end
      end else begin
        h_cnt_next = h_cnt_reg + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  logic active_raw;
  logic hsync_raw;
  logic vsync_raw;

  assign active_raw = (h_cnt_reg < H_ACT_C) && (v_cnt_reg < V_ACT_C);
  assign hsync_raw  = ~in_zone(h_cnt_reg, HS_START, HS_END);
  assign vsync_raw  = ~in_zone(v_cnt_reg, VS_START, VS_END);

  rgb_t rgb_reg;
  logic hsync_reg;
  logic vsync_reg;
  logic video_on_reg;

  // All four outputs load on the same strobe so colour and syncs stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_reg      <= BLACK;
      hsync_reg    <= 1'b1;
      vsync_reg    <= 1'b1;
      video_on_reg <= 1'b0;
    end else if (pix_en) begin
      rgb_reg      <= active_raw ? color : BLACK;
      hsync_reg    <= hsync_raw;
      vsync_reg    <= vsync_raw;
      video_on_reg <= active_raw;
    end
  end

  assign colPos     = h_cnt_reg;
  assign rowPos     = v_cnt_reg;
  assign vga_rgb    = rgb_reg;
  assign hsync      = hsync_reg;
  assign vsync      = vsync_reg;
  assign video_on   = video_on_reg;
  assign frame_tick = pix_en && (h_cnt_reg == '0) && (v_cnt_reg == V_ACT_C);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomised bench: two controllers (divide-by-1 and divide-by-3) on a small
// raster, checked every cycle against a pixel-index reference model.
module tb_vga_timing_ctrl;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int DIV_A = 1;
  localparam int DIV_B = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [9:0] col_pos [2];
  logic [9:0] row_pos [2];
  logic [5:0] color [2];
  logic [5:0] vga_rgb [2];
  logic       hsync [2];
  logic       vsync [2];
  logic       video_on [2];
  logic       frame_tick [2];

  logic [5:0] lut [VT][HT];
  int  k = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  bit  check_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [5:0] color_of(input logic [9:0] c, input logic [9:0] r);
    if (int'(r) < VT && int'(c) < HT) return lut[int'(r)][int'(c)];
    return 6'd0;
  endfunction

  always_comb begin
    color[0] = color_of(col_pos[0], row_pos[0]);
    color[1] = color_of(col_pos[1], row_pos[1]);
  end

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(DIV_A)
  ) u_div_a (
    .clk(clk), .rst_n(rst_n),
    .colPos(col_pos[0]), .rowPos(row_pos[0]), .color(color[0]),
    .vga_rgb(vga_rgb[0]), .hsync(hsync[0]), .vsync(vsync[0]),
    .video_on(video_on[0]), .frame_tick(frame_tick[0])
  );

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(DIV_B)
  ) u_div_b (
    .clk(clk), .rst_n(rst_n),
    .colPos(col_pos[1]), .rowPos(row_pos[1]), .color(color[1]),
    .vga_rgb(vga_rgb[1]), .hsync(hsync[1]), .vsync(vsync[1]),
    .video_on(video_on[1]), .frame_tick(frame_tick[1])
  );

  // Clock edges seen since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_inst(input int idx, input string ph);
    int   div, p, pos, h, v, q, qh, qv;
    bit   act, pe;
    logic [5:0] e_rgb;
    logic e_hs, e_vs, e_von, e_ft;
    string pre;
    div = (idx == 0) ? DIV_A : DIV_B;
    pre = $sformatf("div%0d.%s", div, ph);
    p   = k / div;
    pos = p % FRAME;
    h   = pos % HT;
    v   = pos / HT;
    pe  = ((k % div) == (div - 1));
    if (p == 0) begin
      e_rgb = 6'd0; e_hs = 1'b1; e_vs = 1'b1; e_von = 1'b0;
    end else begin
      q   = (p - 1) % FRAME;
      qh  = q % HT;
      qv  = q / HT;
      act = (qh < HA) && (qv < VA);
      e_rgb = act ? lut[qv][qh] : 6'd0;
      e_hs  = !((qh >= HA + HF) && (qh < HA + HF + HS));
      e_vs  = !((qv >= VA + VF) && (qv < VA + VF + VS));
      e_von = act;
    end
    e_ft = pe && (h == 0) && (v == VA);
    chk({pre, ".colPos"},     32'(col_pos[idx]),    32'(h));
    chk({pre, ".rowPos"},     32'(row_pos[idx]),    32'(v));
    chk({pre, ".vga_rgb"},    32'(vga_rgb[idx]),    32'(e_rgb));
    chk({pre, ".hsync"},      32'(hsync[idx]),      32'(e_hs));
    chk({pre, ".vsync"},      32'(vsync[idx]),      32'(e_vs));
    chk({pre, ".video_on"},   32'(video_on[idx]),   32'(e_von));
    chk({pre, ".frame_tick"}, 32'(frame_tick[idx]), 32'(e_ft));
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check_inst(0, "run");
      check_inst(1, "run");
    end
  end

  initial begin
    int len;
    int hold;
    for (int r = 0; r < VT; r++)
      for (int c = 0; c < HT; c++)
        lut[r][c] = 6'($urandom_range(0, 63));

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    check_en = 1'b1;
    #2 rst_n = 1'b1;

    for (int seg = 0; seg < 8; seg++) begin
      len  = (seg == 0) ? 2000 : $urandom_range(200, 1400);
      hold = $urandom_range(0, 3);
      repeat (len) @(posedge clk);
      #($urandom_range(1, 3));
      rst_n = 1'b0;
      #1;
      check_inst(0, "async_rst");
      check_inst(1, "async_rst");
      $display("[TB] segment %0d: ran %0d clk, reset pulse held %0d edges", seg, len, hold);
      repeat (hold) @(posedge clk);
      #2 rst_n = 1'b1;
    end

    repeat (500) @(posedge clk);
    @(negedge clk);
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
